// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - branch funct3 codes and 2-bit BHT counter encodings
package riscv_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t CNT_SNT   = 2'b00;
  localparam bht_cnt_t CNT_WNT   = 2'b01;
  localparam bht_cnt_t CNT_WT    = 2'b10;
  localparam bht_cnt_t CNT_ST    = 2'b11;
  localparam bht_cnt_t CNT_RESET = CNT_WNT;

endpackage

// File: rtl/riscv_sat_counter2.sv
// rtl/riscv_sat_counter2.sv - next-state function of a 2-bit saturating counter
module riscv_sat_counter2
  import riscv_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [1:0] o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_inc && (i_cnt != CNT_ST)) begin
      o_cnt = i_cnt + 2'd1;
    end else if (i_dec && (i_cnt != CNT_SNT)) begin
      o_cnt = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/riscv_branch_predictor.sv
// rtl/riscv_branch_predictor.sv - BHT + tagged BTB fetch prediction, execute-stage
// training, mispredict redirect and saturating performance counters
module riscv_branch_predictor
  import riscv_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = XLEN - IDX_W - 2
) (
  input  logic            i_riscv_bpu_clk,
  input  logic            i_riscv_bpu_rst_n,
  input  logic            i_riscv_bpu_stall,
  input  logic [XLEN-1:0] i_riscv_bpu_pc_f,
  output logic            o_riscv_bpu_predtaken_f,
  output logic [XLEN-1:0] o_riscv_bpu_predtarget_f,
  input  logic            i_riscv_bpu_valid_e,
  input  logic [3:0]      i_riscv_bpu_cond_e,
  input  logic            i_riscv_bpu_taken_e,
  input  logic [XLEN-1:0] i_riscv_bpu_pc_e,
  input  logic [XLEN-1:0] i_riscv_bpu_target_e,
  input  logic            i_riscv_bpu_predtaken_e,
  input  logic [XLEN-1:0] i_riscv_bpu_predtarget_e,
  output logic            o_riscv_bpu_flush,
  output logic [XLEN-1:0] o_riscv_bpu_redirect_pc,
  output logic [31:0]     o_riscv_bpu_br_cnt,
  output logic [31:0]     o_riscv_bpu_mp_cnt
);

  bht_cnt_t          r_bht        [ENTRIES];
  logic              r_btb_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_btb_tag    [ENTRIES];
  logic [XLEN-1:0]   r_btb_target [ENTRIES];
  logic [31:0]       r_br_cnt;
  logic [31:0]       r_mp_cnt;

  logic [IDX_W-1:0]  w_idx_f;
  logic [IDX_W-1:0]  w_idx_e;
  logic [TAG_W-1:0]  w_tag_f;
  logic [TAG_W-1:0]  w_tag_e;
  logic              w_hit;
  logic              w_predtaken;
  logic              w_res;
  logic              w_mp;
  bht_cnt_t          w_bht_next;
  logic              w_unused_ok;

  assign w_idx_f = i_riscv_bpu_pc_f[IDX_W+1:2];
  assign w_tag_f = i_riscv_bpu_pc_f[XLEN-1:IDX_W+2];
  assign w_idx_e = i_riscv_bpu_pc_e[IDX_W+1:2];
  assign w_tag_e = i_riscv_bpu_pc_e[XLEN-1:IDX_W+2];

  // Compressed instructions are not predicted, so the halfword bits and funct3 carry no meaning here
  assign w_unused_ok = ^{i_riscv_bpu_pc_f[1:0], i_riscv_bpu_pc_e[1:0], i_riscv_bpu_cond_e[2:0]};

  assign w_hit       = r_btb_valid[w_idx_f] && (r_btb_tag[w_idx_f] == w_tag_f);
  assign w_predtaken = w_hit && r_bht[w_idx_f][1];

  assign o_riscv_bpu_predtaken_f  = w_predtaken;
  assign o_riscv_bpu_predtarget_f = w_predtaken ? r_btb_target[w_idx_f] : '0;

  // Reset also gates the combinational resolution path so flush/redirect drop with rst_n
  assign w_res = i_riscv_bpu_rst_n && i_riscv_bpu_valid_e && i_riscv_bpu_cond_e[3] && !i_riscv_bpu_stall;
  assign w_mp  = w_res && ((i_riscv_bpu_taken_e != i_riscv_bpu_predtaken_e) ||
                           (i_riscv_bpu_taken_e && (i_riscv_bpu_predtarget_e != i_riscv_bpu_target_e)));

  assign o_riscv_bpu_flush       = w_mp;
  assign o_riscv_bpu_redirect_pc = !w_res ? '0 :
                                   i_riscv_bpu_taken_e ? i_riscv_bpu_target_e :
                                   i_riscv_bpu_pc_e + XLEN'(4);

  assign o_riscv_bpu_br_cnt = r_br_cnt;
  assign o_riscv_bpu_mp_cnt = r_mp_cnt;

  riscv_sat_counter2 u_bht_next (
    .i_cnt (r_bht[w_idx_e]),
    .i_inc (i_riscv_bpu_taken_e),
    .i_dec (!i_riscv_bpu_taken_e),
    .o_cnt (w_bht_next)
  );

  always_ff @(posedge i_riscv_bpu_clk or negedge i_riscv_bpu_rst_n) begin
    if (!i_riscv_bpu_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_bht[i]        <= CNT_RESET;
        r_btb_valid[i]  <= 1'b0;
        r_btb_tag[i]    <= '0;
        r_btb_target[i] <= '0;
      end
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else if (w_res) begin
      r_bht[w_idx_e] <= w_bht_next;
      if (i_riscv_bpu_taken_e) begin
        r_btb_valid[w_idx_e]  <= 1'b1;
        r_btb_tag[w_idx_e]    <= w_tag_e;
        r_btb_target[w_idx_e] <= i_riscv_bpu_target_e;
      end
      if (r_br_cnt != 32'hFFFF_FFFF) begin
        r_br_cnt <= r_br_cnt + 32'd1;
      end
      if (w_mp && (r_mp_cnt != 32'hFFFF_FFFF)) begin
        r_mp_cnt <= r_mp_cnt + 32'd1;
      end
    end
  end

endmodule
